rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 104 ++++++++++
 tb/tb_rom_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-master arbiter in front of a single-port ROM/RAM: m0 instruction fetch, m1 data.
// m1 wins contention until it has been granted MAX_BURST times in a row while m0 waits.
module rom_arbiter #(
    parameter int DEPTH_WORDS = 512,
    parameter int MAX_BURST   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        rom_en_o,
    output logic        rom_we_o,
    output logic [31:0] rom_addr_o,
    output logic [31:0] rom_wdata_o,
    input  logic [31:0] rom_rdata_i
);
    localparam int SW = ($clog2(MAX_BURST + 1) > 3) ? $clog2(MAX_BURST + 1) : 3;

    typedef enum logic [1:0] {S_IDLE, S_M0, S_M1} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] streak;
    logic          at_limit, gnt0, gnt1, any_gnt, sel_we, addr_ok;
    logic [31:0]   sel_addr;
    logic          rsp_rd, rsp_err;
    logic [31:0]   m0_rdata_q, m1_rdata_q;

    assign at_limit = (streak == SW'(MAX_BURST));
    assign gnt0     = !rst && m0_req_i && (!m1_req_i || at_limit);
    assign gnt1     = !rst && m1_req_i && !(m0_req_i && at_limit);
    assign any_gnt  = gnt0 || gnt1;
    assign sel_we   = gnt1 && m1_we_i;
    assign sel_addr = gnt0 ? m0_addr_i : (gnt1 ? m1_addr_i : 32'h0);

    // Writes must also be word aligned; reads ignore the byte offset.
    assign addr_ok  = ({2'b00, sel_addr[31:2]} < 32'(DEPTH_WORDS)) &&
                      (!sel_we || (sel_addr[1:0] == 2'b00));

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign rom_en_o    = any_gnt && addr_ok;
    assign rom_we_o    = sel_we && addr_ok;
    assign rom_addr_o  = sel_addr;
    assign rom_wdata_o = gnt1 ? m1_wdata_i : 32'h0;
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            streak     <= '0;
            rsp_rd     <= 1'b0;
            rsp_err    <= 1'b0;
            m0_rdata_q <= 32'h0;
            m1_rdata_q <= 32'h0;
        end else begin
            state   <= state_nxt;
            rsp_rd  <= any_gnt && !sel_we;
            rsp_err <= any_gnt && !addr_ok;
            if (gnt0)
                m0_rdata_q <= addr_ok ? rom_rdata_i : 32'h0;
            if (gnt1 && !sel_we)
                m1_rdata_q <= addr_ok ? rom_rdata_i : 32'h0;
            // Only m1 grants that make m0 wait count toward the burst limit.
            if (gnt1 && m0_req_i)
                streak <= at_limit ? streak : streak + SW'(1);
            else
                streak <= '0;
        end
    end

    always_comb begin
        state_nxt   = S_IDLE;
        m0_rvalid_o = 1'b0;
        m0_err_o    = 1'b0;
        m1_rvalid_o = 1'b0;
        m1_err_o    = 1'b0;
        if (gnt0)      state_nxt = S_M0;
        else if (gnt1) state_nxt = S_M1;
        case (state)
            S_M0: begin
                m0_rvalid_o = rsp_rd;
                m0_err_o    = rsp_err;
            end
            S_M1: begin
                m1_rvalid_o = rsp_rd;
                m1_err_o    = rsp_err;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: vector table plus burst-limit and reset sequences,
// with a behavioural 512-word memory behind the ROM port.
module tb_rom_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m1_addr_i, m1_wdata_i;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        rom_en_o, rom_we_o;
    logic [31:0] rom_addr_o, rom_wdata_o, rom_rdata_i;

    logic [31:0] mem [512];
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rom_arbiter #(.DEPTH_WORDS(512), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .rom_en_o(rom_en_o), .rom_we_o(rom_we_o), .rom_addr_o(rom_addr_o),
        .rom_wdata_o(rom_wdata_o), .rom_rdata_i(rom_rdata_i)
    );

    assign rom_rdata_i = mem[rom_addr_o[10:2]];
    always @(posedge clk)
        if (rom_en_o && rom_we_o) mem[rom_addr_o[10:2]] <= rom_wdata_o;

    typedef struct {
        logic        m0r;
        logic [31:0] m0a;
        logic        m1r, m1we;
        logic [31:0] m1a, m1wd;
        logic        g0, g1, en, we;
        logic [31:0] addr;
        logic        v0, e0;
        logic [31:0] d0;
        logic        v1, e1;
        logic [31:0] d1;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic [31:0] a0, input logic r1,
                         input logic w1, input logic [31:0] a1, input logic [31:0] wd);
        m0_req_i = r0; m0_addr_i = a0;
        m1_req_i = r1; m1_we_i = w1; m1_addr_i = a1; m1_wdata_i = wd;
    endtask

    // Both masters read continuously; pat bit i (MSB first) = 1 means m0 expected.
    task automatic burst(input string tag, input int n, input logic [15:0] pat);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
            #1;
            chk($sformatf("%s g0[%0d]", tag, i), {31'b0, m0_gnt_o}, {31'b0, pat[n-1-i]});
            chk($sformatf("%s g1[%0d]", tag, i), {31'b0, m1_gnt_o}, {31'b0, !pat[n-1-i]});
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int k = 0; k < 512; k++) mem[k] = 32'hA000_0000 + k;
        mem[0] = 32'h1000_1197; mem[1] = 32'h8001_8193; mem[2] = 32'h1000_4117;

        //            m0r m0a        m1r we m1a        m1wd        g0 g1 en we addr       v0 e0 d0            v1 e1 d1
        tbl[0]  = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   0, 0, 32'h0,         0, 0, 32'h0};
        tbl[1]  = '{1, 32'h0,   0, 0, 32'h0,   32'h0,        1, 0, 1, 0, 32'h0,   0, 0, 32'h0,         0, 0, 32'h0};
        tbl[2]  = '{1, 32'h4,   0, 0, 32'h0,   32'h0,        1, 0, 1, 0, 32'h4,   1, 0, 32'h10001197,  0, 0, 32'h0};
        tbl[3]  = '{1, 32'h8,   0, 0, 32'h0,   32'h0,        1, 0, 1, 0, 32'h8,   1, 0, 32'h80018193,  0, 0, 32'h0};
        tbl[4]  = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   1, 0, 32'h10004117,  0, 0, 32'h0};
        tbl[5]  = '{0, 32'h0,   1, 1, 32'h10,  32'hDEADBEEF, 0, 1, 1, 1, 32'h10,  0, 0, 32'h10004117,  0, 0, 32'h0};
        tbl[6]  = '{1, 32'h10,  0, 0, 32'h0,   32'h0,        1, 0, 1, 0, 32'h10,  0, 0, 32'h10004117,  0, 0, 32'h0};
        tbl[7]  = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   1, 0, 32'hDEADBEEF,  0, 0, 32'h0};
        tbl[8]  = '{0, 32'h0,   1, 0, 32'h800, 32'h0,        0, 1, 0, 0, 32'h800, 0, 0, 32'hDEADBEEF,  0, 0, 32'h0};
        tbl[9]  = '{0, 32'h0,   1, 1, 32'h12,  32'h5,        0, 1, 0, 0, 32'h12,  0, 0, 32'hDEADBEEF,  1, 1, 32'h0};
        tbl[10] = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   0, 0, 32'hDEADBEEF,  0, 1, 32'h0};
        tbl[11] = '{0, 32'h0,   1, 0, 32'h7FC, 32'h0,        0, 1, 1, 0, 32'h7FC, 0, 0, 32'hDEADBEEF,  0, 0, 32'h0};
        tbl[12] = '{0, 32'h0,   1, 0, 32'h20,  32'h0,        0, 1, 1, 0, 32'h20,  0, 0, 32'hDEADBEEF,  1, 0, 32'hA00001FF};
        tbl[13] = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   0, 0, 32'hDEADBEEF,  1, 0, 32'hA0000008};
        tbl[14] = '{1, 32'h800, 0, 0, 32'h0,   32'h0,        1, 0, 0, 0, 32'h800, 0, 0, 32'hDEADBEEF,  0, 0, 32'hA0000008};
        tbl[15] = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   1, 1, 32'h0,         0, 0, 32'hA0000008};
        tbl[16] = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   0, 0, 32'h0,         0, 0, 32'hA0000008};

        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(tbl[i].m0r, tbl[i].m0a, tbl[i].m1r, tbl[i].m1we, tbl[i].m1a, tbl[i].m1wd);
            #1;
            chk($sformatf("v%0d m0_gnt", i),    {31'b0, m0_gnt_o},    {31'b0, tbl[i].g0});
            chk($sformatf("v%0d m1_gnt", i),    {31'b0, m1_gnt_o},    {31'b0, tbl[i].g1});
            chk($sformatf("v%0d rom_en", i),    {31'b0, rom_en_o},    {31'b0, tbl[i].en});
            chk($sformatf("v%0d rom_we", i),    {31'b0, rom_we_o},    {31'b0, tbl[i].we});
            chk($sformatf("v%0d rom_addr", i),  rom_addr_o,           tbl[i].addr);
            chk($sformatf("v%0d m0_rvalid", i), {31'b0, m0_rvalid_o}, {31'b0, tbl[i].v0});
            chk($sformatf("v%0d m0_err", i),    {31'b0, m0_err_o},    {31'b0, tbl[i].e0});
            chk($sformatf("v%0d m0_rdata", i),  m0_rdata_o,           tbl[i].d0);
            chk($sformatf("v%0d m1_rvalid", i), {31'b0, m1_rvalid_o}, {31'b0, tbl[i].v1});
            chk($sformatf("v%0d m1_err", i),    {31'b0, m1_err_o},    {31'b0, tbl[i].e1});
            chk($sformatf("v%0d m1_rdata", i),  m1_rdata_o,           tbl[i].d1);
        end
        chk("written word in memory", mem[4], 32'hDEADBEEF);

        // Contention: m1,m1,m1,m1,m0 repeating.
        burst("burst", 10, 16'b00001_00001);
        idle_cycle();

        // A cycle with m0 idle clears the streak.
        burst("pre-drop", 2, 16'b00);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        burst("post-drop", 5, 16'b00001);
        idle_cycle();

        // Reset right after an m0 grant kills the response and the streak.
        burst("pre-rst", 2, 16'b00);
        @(negedge clk);
        drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 chk("pre-rst m0_gnt", {31'b0, m0_gnt_o}, 32'h1);
        @(negedge clk);
        drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h4, 32'h0);
        rst = 1'b1;
        #1;
        chk("rst m0_gnt",    {31'b0, m0_gnt_o},    32'h0);
        chk("rst m1_gnt",    {31'b0, m1_gnt_o},    32'h0);
        chk("rst rom_en",    {31'b0, rom_en_o},    32'h0);
        chk("rst rom_we",    {31'b0, rom_we_o},    32'h0);
        chk("rst m0_rvalid", {31'b0, m0_rvalid_o}, 32'h0);
        chk("rst m0_rdata",  m0_rdata_o,           32'h0);
        chk("rst m1_rdata",  m1_rdata_o,           32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post-rst m0_rvalid[%0d]", i), {31'b0, m0_rvalid_o}, 32'h0);
            chk($sformatf("post-rst m0_rdata[%0d]", i),  m0_rdata_o,           32'h0);
        end
        burst("post-rst", 5, 16'b00001);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
